key_event_sequencer: RTL and testbench

KEY_EVENT_SEQUENCER -- requirements
Module: key_event_sequencer

---
 rtl/key_event_sequencer.sv | 141 ++++++++++++++
 tb/tb_key_event_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_sequencer.sv
// PS/2 scan-code sequencer: folds E0/F0 prefix sequences into a held-key code with make/error pulses.
// Build option: define KEY_TYPEMATIC_EN to pulse key_valid on every typematic repeat of the held key.
module key_event_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_valid,
  output logic       seq_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_t;

  localparam logic [7:0]  CODE_EXT = 8'hE0;
  localparam logic [7:0]  CODE_BRK = 8'hF0;
  localparam logic [16:0] TMO_LAST = 17'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [16:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]  key_code_q, key_code_d;
  logic        key_ext_q, key_ext_d;
  logic        key_valid_q, key_valid_d;
  logic        seq_err_q, seq_err_d;

  logic        bad_byte;
  logic        make_req;
  logic        make_ext;
  logic        brk_match;

  assign bad_byte = (rx_data == 8'h00) || (rx_data == 8'hFF);

  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_valid_d = 1'b0;
    seq_err_d   = 1'b0;
    make_req    = 1'b0;
    make_ext    = 1'b0;
    brk_match   = 1'b0;

    if (rx_done) begin
      // Every accepted byte restarts the prefix timeout.
      tmo_cnt_d = '0;
      unique case (state_q)
        ST_IDLE: begin
          if (rx_data == CODE_EXT) begin
            state_d = ST_EXT;
          end else if (rx_data == CODE_BRK) begin
            state_d = ST_BRK;
          end else if (bad_byte) begin
            seq_err_d = 1'b1;
          end else begin
            make_req = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_data == CODE_BRK) begin
            state_d = ST_EXT_BRK;
          end else if (rx_data == CODE_EXT) begin
            state_d = ST_EXT;
          end else if (bad_byte) begin
            state_d   = ST_IDLE;
            seq_err_d = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            make_req = 1'b1;
            make_ext = 1'b1;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          state_d   = ST_IDLE;
          brk_match = (rx_data == key_code_q) &&
                      (key_ext_q == (state_q == ST_EXT_BRK));
          if (brk_match) begin
            key_code_d = 8'h00;
            key_ext_d  = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmo_cnt_q == TMO_LAST) begin
        state_d   = ST_IDLE;
        tmo_cnt_d = '0;
        seq_err_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 17'd1;
      end
    end

    // A make of the already-held key/extension is a typematic repeat.
    if (make_req) begin
      if ((rx_data != key_code_q) || (make_ext != key_ext_q)) begin
        key_code_d  = rx_data;
        key_ext_d   = make_ext;
        key_valid_d = 1'b1;
      end else begin
`ifdef KEY_TYPEMATIC_EN
        key_valid_d = 1'b1;
`else
        key_valid_d = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tmo_cnt_q   <= '0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_valid_q <= key_valid_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_valid = key_valid_q;
  assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_key_event_sequencer.sv
// Directed bench for key_event_sequencer: make/break, extended keys, typematic, timeout, errors, reset.
module tb_key_event_sequencer;

  localparam int unsigned TB_TIMEOUT = 20;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_valid;
  logic       seq_err;

  int checks = 0;
  int errors = 0;
  int kv_cnt = 0;
  int se_cnt = 0;
  bit both_seen = 1'b0;

  key_event_sequencer #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .key_code (key_code),
    .key_ext  (key_ext),
    .key_valid(key_valid),
    .seq_err  (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    if (key_valid === 1'b1) kv_cnt++;
    if (seq_err === 1'b1) se_cnt++;
    if (key_valid === 1'b1 && seq_err === 1'b1) both_seen = 1'b1;
  end

  // Called at a falling edge; returns at the next falling edge with the byte's result visible.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic chk_key(input string name, input logic [7:0] exp_code, input logic exp_ext);
    checks++;
    if (key_code !== exp_code || key_ext !== exp_ext) begin
      errors++;
      $display("FAIL %s: key_code=%h key_ext=%b, expected key_code=%h key_ext=%b",
               name, key_code, key_ext, exp_code, exp_ext);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    #2 reset = 1'b1;
    #1;
    chk_key("reset_key", 8'h00, 1'b0);
    checks++;
    if (key_valid !== 1'b0 || seq_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: key_valid=%b seq_err=%b, expected 0 0", key_valid, seq_err);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_make_break;
    int kv0, se0;
    kv0 = kv_cnt; se0 = se_cnt;
    send_byte(8'h5A);
    chk_key("mb_make", 8'h5A, 1'b0);
    chk_int("mb_valid_aligned", int'(key_valid), 1);
    send_byte(8'hF0);
    chk_key("mb_prefix_hold", 8'h5A, 1'b0);
    send_byte(8'h5A);
    chk_key("mb_break", 8'h00, 1'b0);
    chk_int("mb_valid_count", kv_cnt - kv0, 1);
    chk_int("mb_err_count", se_cnt - se0, 0);
  endtask

  task automatic test_extended;
    int kv0, se0;
    kv0 = kv_cnt; se0 = se_cnt;
    send_byte(8'hE0);
    send_byte(8'h75);
    chk_key("ext_make", 8'h75, 1'b1);
    chk_int("ext_valid_aligned", int'(key_valid), 1);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    chk_key("ext_break", 8'h00, 1'b0);
    chk_int("ext_valid_count", kv_cnt - kv0, 1);
    chk_int("ext_err_count", se_cnt - se0, 0);
  endtask

  task automatic test_typematic;
    int kv0, exp_kv;
`ifdef KEY_TYPEMATIC_EN
    exp_kv = 3;
`else
    exp_kv = 1;
`endif
    kv0 = kv_cnt;
    for (int unsigned i = 0; i < 3; i++) begin
      send_byte(8'h16);
      chk_key("typ_hold", 8'h16, 1'b0);
    end
    chk_int("typ_valid_count", kv_cnt - kv0, exp_kv);
  endtask

  task automatic test_timeout;
    int kv0, se0;
    send_byte(8'h2C);
    se0 = se_cnt;
    send_byte(8'hF0);
    repeat (TB_TIMEOUT - 1) @(negedge clk);
    chk_int("tmo_not_early", se_cnt - se0, 0);
    @(negedge clk);
    chk_int("tmo_fires", int'(seq_err), 1);
    chk_key("tmo_key_kept", 8'h2C, 1'b0);
    @(negedge clk);
    chk_int("tmo_one_pulse", se_cnt - se0, 1);
    kv0 = kv_cnt;
    send_byte(8'h33);
    chk_key("tmo_then_make", 8'h33, 1'b0);
    chk_int("tmo_then_valid", kv_cnt - kv0, 1);
  endtask

  task automatic test_timeout_race;
    int se0;
    se0 = se_cnt;
    send_byte(8'hF0);
    repeat (TB_TIMEOUT - 1) @(negedge clk);
    send_byte(8'h33);
    chk_key("race_break_taken", 8'h00, 1'b0);
    repeat (TB_TIMEOUT + 2) @(negedge clk);
    chk_int("race_no_err", se_cnt - se0, 0);
  endtask

  task automatic test_prefix_restart;
    int se0;
    se0 = se_cnt;
    send_byte(8'hE0);
    repeat (TB_TIMEOUT - 2) @(negedge clk);
    send_byte(8'hE0);
    repeat (TB_TIMEOUT - 1) @(negedge clk);
    chk_int("restart_not_early", se_cnt - se0, 0);
    @(negedge clk);
    chk_int("restart_fires", int'(seq_err), 1);
    chk_key("restart_key_kept", 8'h00, 1'b0);
  endtask

  task automatic test_errors;
    int se0, kv0;
    se0 = se_cnt;
    send_byte(8'h29);
    send_byte(8'hF0);
    send_byte(8'h22);
    chk_key("mism_break_hold", 8'h29, 1'b0);
    chk_int("mism_no_err", se_cnt - se0, 0);
    send_byte(8'hFF);
    chk_int("ff_err_pulse", int'(seq_err), 1);
    chk_key("ff_key_kept", 8'h29, 1'b0);
    send_byte(8'hE0);
    send_byte(8'h00);
    chk_int("ext00_err_pulse", int'(seq_err), 1);
    chk_int("err_count", se_cnt - se0, 2);
    send_byte(8'h4B);
    chk_key("after_err_idle", 8'h4B, 1'b0);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h4B);
    chk_key("ext_mismatch_break", 8'h4B, 1'b0);
    kv0 = kv_cnt;
    send_byte(8'hE0);
    send_byte(8'h4B);
    chk_key("ext_same_code", 8'h4B, 1'b1);
    chk_int("ext_same_code_valid", kv_cnt - kv0, 1);
  endtask

  task automatic test_reset_mid;
    int kv0;
    send_byte(8'hE0);
    #2 reset = 1'b1;
    #1;
    chk_key("rst_mid_clear", 8'h00, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    kv0 = kv_cnt;
    send_byte(8'h1E);
    chk_key("rst_mid_decode", 8'h1E, 1'b0);
    chk_int("rst_mid_valid", kv_cnt - kv0, 1);
  endtask

  task automatic test_exclusive;
    chk_int("valid_err_exclusive", int'(both_seen), 0);
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_typematic();
    test_timeout();
    test_timeout_race();
    test_prefix_restart();
    test_errors();
    test_reset_mid();
    repeat (2) @(negedge clk);
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
